// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// FSM states, aluop and alucontrol codes.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_aludec.sv
// Combinational ALU decoder: maps the FSM's aluop and the R-type funct
// field onto the shared ALU's operation code.
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared ALU, the
// unified memory port and the register file, one instruction at a time.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  state_t     state_n;
  logic [3:0] cur;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;

  // While reset is high the outputs decode as FETCH, so an abandoned
  // instruction cannot leak any select values onto the datapath.
  assign cur   = reset ? S_FETCH : state_q;
  assign state = STATE_W'(cur);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n    = S_FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (cur)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = 1'b1;
        state_n   = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTYPEEX;
          OP_BEQ:       state_n = S_BEQEX;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JEX;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_n = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_n = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
  end

  assign irwrite  = irwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

  mips_mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
